// File: rtl/rr_index_arbiter_8.sv
// Round-robin arbiter over 8 requesters: latches one winner index, holds it until
// valid & ready, then pulses a one-hot ack and advances the pointer past the winner.
module rr_index_arbiter_8 #(
  parameter logic [2:0] PRIO_RESET = 3'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       ready,
  output logic       valid,
  output logic [2:0] idx,
  output logic [7:0] ack,
  output logic       busy
);

  // Handshake: idx is offered while valid=1 and held stable until a cycle
  // in which valid & ready are both high; ready is ignored while valid=0.
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state, state_nxt;
  logic [2:0] ptr, ptr_nxt;
  logic [2:0] idx_nxt;
  logic [7:0] ack_nxt;
  logic [2:0] winner;
  logic [2:0] cand;
  logic       found;

  // Search starts at ptr and wraps 7 -> 0; the first set request wins.
  always_comb begin
    winner = 3'd0;
    found  = 1'b0;
    cand   = 3'd0;
    for (int k = 0; k < 8; k++) begin
      cand = ptr + 3'(k);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    idx_nxt   = idx;
    ack_nxt   = 8'd0;
    case (state)
      IDLE: begin
        if (found) begin
          idx_nxt   = winner;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (ready) begin
          ack_nxt   = 8'd1 << idx;
          ptr_nxt   = idx + 3'd1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= PRIO_RESET;
      idx   <= 3'd0;
      ack   <= 8'd0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      idx   <= idx_nxt;
      ack   <= ack_nxt;
    end
  end

  // Both flags are the state flop itself, so neither depends on a live input.
  assign valid = (state == GRANT);
  assign busy  = (state == GRANT);

endmodule

// File: tb/tb_rr_index_arbiter_8.sv
// Bench for rr_index_arbiter_8: directed literal checks plus randomized traffic
// compared every cycle against a pointer/index reference model.
module tb_rr_index_arbiter_8;

  // ---------------- clock / reset ----------------
  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       ready;
  logic       valid;
  logic [2:0] idx;
  logic [7:0] ack;
  logic       busy;

  logic       rst6;
  logic [7:0] req6;
  logic       ready6;
  logic       valid6;
  logic [2:0] idx6;
  logic [7:0] ack6;
  logic       busy6;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  rr_index_arbiter_8 #(.PRIO_RESET(3'd0)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .ready(ready),
    .valid(valid), .idx(idx), .ack(ack), .busy(busy)
  );

  rr_index_arbiter_8 #(.PRIO_RESET(3'd6)) u_dut6 (
    .clk(clk), .rst_n(rst6), .req(req6), .ready(ready6),
    .valid(valid6), .idx(idx6), .ack(ack6), .busy(busy6)
  );

  // ---------------- scoreboard counters ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int         m_ptr;
  int         m_idx;
  bit         m_valid;
  logic [7:0] m_ack;
  bit         m_init = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_ptr   = 0;
      m_idx   = 0;
      m_valid = 1'b0;
      m_ack   = 8'd0;
      m_init  = 1'b1;
    end else if (m_valid) begin
      m_ack = 8'd0;
      if (ready) begin
        m_ack   = 8'd1 << m_idx;
        m_ptr   = (m_idx + 1) % 8;
        m_valid = 1'b0;
      end
    end else begin
      m_ack = 8'd0;
      if (req != 8'd0) begin
        bit hit;
        hit = 1'b0;
        for (int k = 0; k < 8; k++) begin
          if (!hit && req[(m_ptr + k) % 8]) begin
            m_idx = (m_ptr + k) % 8;
            hit   = 1'b1;
          end
        end
        m_valid = 1'b1;
      end
    end
  end

  // Every-cycle compare, sampled away from the active edge.
  always @(negedge clk) begin
    if (m_init) begin
      check("valid", {31'd0, valid}, {31'd0, m_valid});
      check("busy",  {31'd0, busy},  {31'd0, m_valid});
      check("idx",   {29'd0, idx},   32'(m_idx));
      check("ack",   {24'd0, ack},   {24'd0, m_ack});
    end
  end

  // ---------------- driver ----------------
  task automatic step(input logic [7:0] r, input logic rd);
    req   = r;
    ready = rd;
    @(negedge clk);
  endtask

  initial begin
    rst_n  = 1'b0;
    rst6   = 1'b0;
    req    = 8'd0;
    ready  = 1'b0;
    req6   = 8'b0100_0001;
    ready6 = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_idx",   {29'd0, idx},   32'd0);
    check("rst_ack",   {24'd0, ack},   32'd0);
    check("rst_busy",  {31'd0, busy},  32'd0);

    // single request, first arbitration on the first cycle out of reset
    rst_n = 1'b1;
    rst6  = 1'b1;
    step(8'h04, 1'b1);
    check("lit_grant2_valid", {31'd0, valid}, 32'd1);
    check("lit_grant2_idx",   {29'd0, idx},   32'd2);
    check("p6_first_idx",     {29'd0, idx6},  32'd6);
    step(8'h00, 1'b1);
    check("lit_ack2",        {24'd0, ack},  32'h04);
    check("lit_ack2_valid",  {31'd0, valid}, 32'd0);
    check("p6_first_ack",    {24'd0, ack6}, 32'h40);
    step(8'h00, 1'b1);
    check("p6_second_idx",   {29'd0, idx6}, 32'd0);
    check("p6_second_valid", {31'd0, valid6}, 32'd1);

    // wrap: grant 6 so ptr=7, then req 0 and 1
    step(8'h40, 1'b1);
    step(8'h00, 1'b1);
    step(8'h03, 1'b1);
    check("lit_wrap_idx0", {29'd0, idx}, 32'd0);
    step(8'h03, 1'b1);
    check("lit_wrap_ack0", {24'd0, ack}, 32'h01);
    step(8'h03, 1'b1);
    check("lit_wrap_idx1", {29'd0, idx}, 32'd1);
    step(8'h00, 1'b1);

    // backpressure with req churn during the grant
    step(8'h20, 1'b0);
    check("lit_bp_idx", {29'd0, idx}, 32'd5);
    step(8'h00, 1'b0);
    step(8'h02, 1'b0);
    step(8'h02, 1'b0);
    check("lit_bp_hold_idx",   {29'd0, idx},   32'd5);
    check("lit_bp_hold_valid", {31'd0, valid}, 32'd1);
    step(8'h02, 1'b1);
    check("lit_bp_ack", {24'd0, ack}, 32'h20);
    step(8'h02, 1'b1);
    check("lit_bp_next_idx", {29'd0, idx}, 32'd1);
    step(8'h00, 1'b1);

    // reset mid-grant with a simultaneous ready
    step(8'h08, 1'b0);
    check("lit_mid_idx3", {29'd0, idx}, 32'd3);
    rst_n = 1'b0;
    step(8'h08, 1'b1);
    check("lit_mid_rst_valid", {31'd0, valid}, 32'd0);
    check("lit_mid_rst_idx",   {29'd0, idx},   32'd0);
    check("lit_mid_rst_ack",   {24'd0, ack},   32'd0);
    rst_n = 1'b1;

    // fairness: all requests, ready tied high, 16 grants from ptr=0
    step(8'hFF, 1'b1);
    check("lit_fair_idx0", {29'd0, idx}, 32'd0);
    for (int g = 1; g < 16; g++) begin
      step(8'hFF, 1'b1);
      check("lit_fair_ack", {24'd0, ack}, 32'(8'd1 << ((g - 1) % 8)));
      step(8'hFF, 1'b1);
      check("lit_fair_idx", {29'd0, idx}, 32'(g % 8));
    end
    step(8'h00, 1'b1);
    check("lit_fair_last_ack", {24'd0, ack}, 32'h80);

    // randomized traffic, including occasional resets
    for (int c = 0; c < 3000; c++) begin
      logic [7:0] r;
      case ($urandom_range(0, 3))
        0:       r = 8'd0;
        1:       r = 8'd1 << $urandom_range(0, 7);
        default: r = 8'($urandom_range(0, 255));
      endcase
      rst_n = ($urandom_range(0, 63) != 0);
      step(r, ($urandom_range(0, 3) != 0));
    end
    rst_n = 1'b1;
    step(8'h00, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
